// File: rtl/prio_arb_enc.sv
// prio_arb_enc: registered N-input arbiter / priority encoder.
// Chooses one requester under fixed (highest index wins) or round-robin
// priority. Holds the grant until the consumer acks it, and can re-grant
// back-to-back on the same edge as the ack.
module prio_arb_enc #(
    parameter int N     = 8,
    parameter int W     = $clog2(N),
    parameter int RR_EN = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic         rr_mode,
    input  logic         ack,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_oh,
    output logic         any_req
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic         state;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_nxt;
    logic         rr_eff;
    logic [N-1:0] cand;
    logic         load;
    logic [W-1:0] win;
    logic [N-1:0] win_oh;

    // Highest set index of v.
    function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[W'(i)]) r = W'(i);
        end
        return r;
    endfunction

    // First set bit searching p, p-1, ..., 0, N-1, ..., p+1. The loop runs
    // from the lowest-priority slot up so the highest-priority hit is the
    // last assignment.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] v,
                                             input logic [W-1:0] p);
        logic [W-1:0] r;
        logic [W-1:0] pw;
        r = '0;
        for (int unsigned k = N; k > 0; k--) begin
            pw = W'((32'(p) + 32'(N) + 32'd1 - k) % 32'(N));
            if (v[pw]) r = pw;
        end
        return r;
    endfunction

    // Next pointer, candidate set and winner for this edge.
    always_comb begin
        rr_eff  = (RR_EN != 0) && rr_mode;
        ptr_nxt = ptr;
        if (state == ST_GRANT && ack && rr_eff) begin
            ptr_nxt = (gnt_idx == '0) ? W'(N - 1) : gnt_idx - W'(1);
        end
        // A back-to-back decision excludes the source just served.
        cand   = (state == ST_GRANT) ? (req & ~gnt_oh) : req;
        load   = en && (|cand) && (state == ST_IDLE || ack);
        win    = rr_eff ? rr_pick(cand, ptr_nxt) : fixed_pick(cand);
        win_oh = '0;
        win_oh[win] = 1'b1;
    end

    // Grant state, held outputs, round-robin pointer and request summary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= W'(N - 1);
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            gnt_oh    <= '0;
            any_req   <= 1'b0;
        end else begin
            any_req <= |req;
            ptr     <= ptr_nxt;
            if (load) begin
                state     <= ST_GRANT;
                gnt_valid <= 1'b1;
                gnt_idx   <= win;
                gnt_oh    <= win_oh;
            end else if (state == ST_GRANT && !ack) begin
                state <= ST_GRANT;
            end else begin
                state     <= ST_IDLE;
                gnt_valid <= 1'b0;
                gnt_idx   <= '0;
                gnt_oh    <= '0;
            end
        end
    end

endmodule
